// File: rtl/xor_link_pkg.sv
// Shared definitions for the nibble XOR link: link states, default LFSR constants
// and the 4-step Galois LFSR used by both the scrambler and the descrambler.
package xor_link_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } link_state_e;

    localparam int         LFSR_MAX_W = 32;
    localparam logic [7:0] TAPS_DEF   = 8'hB8;
    localparam logic [7:0] SEED_DEF   = 8'h01;

    // Operates on a zero-extended state so one function serves any LFSR_W up to
    // LFSR_MAX_W. Returns {next_state, keystream[3:0]}, keystream[0] produced first.
    function automatic logic [LFSR_MAX_W+3:0] lfsr_step4(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        logic [LFSR_MAX_W-1:0] s;
        logic [3:0]            ks;
        s  = state;
        ks = '0;
        for (int i = 0; i < 4; i++) begin
            ks[i] = s[0];
            s     = (s >> 1) ^ (s[0] ? taps : '0);
        end
        return {s, ks};
    endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Galois LFSR register that yields one keystream nibble per advance; the same
// instance is used on the transmit side so both ends stay in lock-step.
module lfsr_keystream
    import xor_link_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [3:0]        keystream
);

    logic [LFSR_W-1:0]     lfsr_q;
    logic [LFSR_W-1:0]     lfsr_d;
    logic [LFSR_MAX_W+3:0] step;

    always_comb begin
        step = lfsr_step4(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS));
    end

    assign keystream = step[3:0];

    // Bits above LFSR_W are always zero for a zero-extended state and taps.
    if (LFSR_W < LFSR_MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^step[LFSR_MAX_W+3:LFSR_W+4];
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (advance) begin
            lfsr_d = step[LFSR_W+3:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/xor_nibble_descrambler.sv
// Receive end of the nibble XOR link: strips the LFSR keystream from incoming
// nibbles behind a one-entry output register and counts accepted nibbles.
module xor_nibble_descrambler
    import xor_link_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF),
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_data,
    output logic [CNT_W-1:0]  nib_count,
    output logic              lock_err
);

    link_state_e      state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0] nib_count_q, nib_count_d;

    logic       seed_nz;
    logic       seed_ok;
    logic       accept;
    logic [3:0] keystream;

    assign seed_nz = (seed != '0);
    assign seed_ok = seed_load && seed_nz;

    // A seed load blocks acceptance so the old keystream never touches new data.
    assign in_ready = (state_q == S_RUN) && !seed_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    lfsr_keystream #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_keystream (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (seed_ok),
        .seed      (seed),
        .advance   (accept),
        .keystream (keystream)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (seed_load) state_d = seed_nz ? S_RUN : S_ERR;
            S_RUN:  if (seed_load) state_d = seed_nz ? S_RUN : S_ERR;
            S_ERR:  if (seed_ok)   state_d = S_RUN;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        nib_count_d = nib_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ keystream;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (seed_ok) begin
            nib_count_d = '0;
        end else if (accept) begin
            nib_count_d = nib_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            nib_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            nib_count_q <= nib_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign nib_count = nib_count_q;
    assign lock_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_xor_nibble_descrambler.sv
// Directed bench for xor_nibble_descrambler: a transaction-level link model is
// compared every cycle, with hand-computed vectors pinning the model.
module tb_xor_nibble_descrambler;

    localparam int         LFSR_W = 8;
    localparam int         CNT_W  = 8;
    localparam logic [7:0] TAPS   = 8'hB8;

    logic             clk;
    logic             rst_n;
    logic             seed_load;
    logic [LFSR_W-1:0] seed;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [CNT_W-1:0] nib_count;
    logic             lock_err;

    xor_nibble_descrambler #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .nib_count (nib_count),
        .lock_err  (lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Link model: 0 idle, 1 running, 2 locked out by a zero seed.
    int         m_state;
    int         m_lfsr;
    int         m_cnt;
    logic       m_ov;
    logic [3:0] m_od;

    function automatic int ks_run(input int s, input bit want_key);
        int key;
        int b;
        key = 0;
        for (int i = 0; i < 4; i++) begin
            b = s % 2;
            s = s / 2;
            if (b == 1) s = s ^ int'(TAPS);
            key = key + (b << i);
        end
        return want_key ? key : s;
    endfunction

    function automatic bit m_ready();
        return (m_state == 1) && !seed_load && (!m_ov || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_lfsr  <= 0;
            m_cnt   <= 0;
            m_ov    <= 1'b0;
            m_od    <= 4'h0;
        end else begin
            if (seed_load) begin
                if (seed != 0) begin
                    m_state <= 1;
                    m_lfsr  <= int'(seed);
                    m_cnt   <= 0;
                end else begin
                    m_state <= 2;
                end
            end
            if (in_valid && m_ready()) begin
                m_ov   <= 1'b1;
                m_od   <= 4'(int'(in_data) ^ ks_run(m_lfsr, 1'b1));
                m_lfsr <= ks_run(m_lfsr, 1'b0);
                m_cnt  <= (m_cnt + 1) % (1 << CNT_W);
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("nib_count", 32'(nib_count), 32'(m_cnt));
            chk("lock_err", 32'(lock_err), 32'(m_state == 2));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) cycle();
        rst_n = 1'b1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset nib_count", 32'(nib_count), 32'h0);
        chk("reset lock_err", 32'(lock_err), 32'h0);

        // Idle: no seed yet, input must be refused.
        in_valid = 1'b1; in_data = 4'hA;
        #1 chk("idle in_ready", 32'(in_ready), 32'h0);
        repeat (2) cycle();
        chk("idle no output", 32'(out_valid), 32'h0);

        // Known vector with seed 0x01.
        in_valid = 1'b0; seed_load = 1'b1; seed = 8'h01;
        cycle();
        seed_load = 1'b0;
        in_valid = 1'b1; in_data = 4'h5;
        cycle();
        chk("vec0 out_data", 32'(out_data), 32'h4);
        in_data = 4'h0;
        cycle();
        chk("vec1 out_data", 32'(out_data), 32'h7);
        chk("vec nib_count", 32'(nib_count), 32'h2);

        // Backpressure: keystream now from 0x64.
        in_data = 4'h3;
        cycle();
        out_ready = 1'b0; in_data = 4'h9;
        #1 chk("bp in_ready low", 32'(in_ready), 32'h0);
        repeat (2) cycle();
        chk("bp held data", 32'(out_data), 32'h7);
        chk("bp held valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        #1 chk("bp in_ready high", 32'(in_ready), 32'h1);
        cycle();
        chk("bp next data", 32'(out_data), 32'h3);
        chk("bp nib_count", 32'(nib_count), 32'h4);
        in_valid = 1'b0;
        cycle();

        // Zero seed lockout, then recovery.
        seed_load = 1'b1; seed = 8'h00;
        cycle();
        seed_load = 1'b0; in_valid = 1'b1; in_data = 4'h0;
        #1 chk("err lock_err", 32'(lock_err), 32'h1);
        chk("err in_ready", 32'(in_ready), 32'h0);
        cycle();
        in_valid = 1'b0; seed_load = 1'b1; seed = 8'h01;
        cycle();
        seed_load = 1'b0;
        chk("recover lock_err", 32'(lock_err), 32'h0);
        in_valid = 1'b1; in_data = 4'h0;
        cycle();
        chk("recover keystream", 32'(out_data), 32'h1);
        in_valid = 1'b0;
        cycle();

        // Re-seed colliding with an input while an output is pending.
        in_valid = 1'b1; in_data = 4'h2;
        cycle();
        out_ready = 1'b0; seed_load = 1'b1; seed = 8'h01;
        #1 chk("collide in_ready", 32'(in_ready), 32'h0);
        cycle();
        seed_load = 1'b0;
        chk("collide pending kept", 32'(out_valid), 32'h1);
        chk("collide nib_count", 32'(nib_count), 32'h0);
        out_ready = 1'b1; in_data = 4'h5;
        cycle();
        chk("collide new keystream", 32'(out_data), 32'h4);
        in_valid = 1'b0;
        cycle();

        // Streaming 300 nibbles at full rate; counter wraps to 44.
        seed_load = 1'b1; seed = 8'h01;
        cycle();
        seed_load = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'($urandom_range(0, 15));
            cycle();
        end
        chk("stream nib_count", 32'(nib_count), 32'd44);
        chk("stream out_valid", 32'(out_valid), 32'h1);

        // Asynchronous reset in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'h0);
        chk("async out_data", 32'(out_data), 32'h0);
        chk("async nib_count", 32'(nib_count), 32'h0);
        chk("async lock_err", 32'(lock_err), 32'h0);
        cycle();
        rst_n = 1'b1;
        #1 chk("post reset in_ready", 32'(in_ready), 32'h0);
        repeat (2) cycle();
        in_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
